ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Consumer-side controller for the PS/2 keyboard receiver FIFO. It pops scan-code bytes using the receiver's `ready`/`nextdata_n` handshake and decodes the `E0` (extended) and `F0` (break) prefixes into make/release events. It tracks the currently held key and counts distinct key presses. It sits between `ps2_keyboard` and the seven-segment drivers, replacing the tie-off of `nextdata_n`.

## Interface
Parameters:
- `COUNT_W`, 8: width of the press counter.

Ports:
- `clk` in 1: system clock.
- `clrn` in 1: reset, synchronous, active-low.
- `ready` in 1: receiver FIFO non-empty.
- `data` in 8: byte at the FIFO head; valid while `ready`=1.
- `overflow` in 1: receiver FIFO overflow indication.
- `nextdata_n` out 1: registered pop strobe, active-low, to the receiver.
- `key_code` out 8: code byte of the last make event (prefixes stripped).
- `key_ext` out 1: last make event was `E0`-prefixed.
- `key_down` out 1: the key in `key_code`/`key_ext` is currently held.
- `press_pulse` out 1: one-cycle strobe on each new press.
- `release_pulse` out 1: one-cycle strobe on each break event.
- `press_count` out COUNT_W: number of new presses.
- `ovf_sticky` out 1: an overflow has occurred since reset.

## Operation
- States:
  - IDLE: if `ready`=1, latch `data` into `byte_r`, drive `nextdata_n`<=0, go to POP. Otherwise stay in IDLE.
  - POP: drive `nextdata_n`<=1, go to PROC. The receiver advances its read pointer at the edge ending POP.
  - PROC: decode `byte_r`, go to IDLE.
- Decode in PROC:
  - `E0`: set `ext_pend`.
  - `F0`: set `brk_pend`.
  - Any other byte X with `brk_pend`=1 (break):
    - Pulse `release_pulse`.
    - If X==`key_code` and `ext_pend`==`key_ext`, clear `key_down`; otherwise `key_down` is unchanged.
    - Clear both pending flags.
  - Any other byte X with `brk_pend`=0 (make):
    - If `key_down`=1 with matching code and ext, the event is typematic repeat: no pulse, no count.
    - Otherwise: `key_code`<=X, `key_ext`<=`ext_pend`, `key_down`<=1, pulse `press_pulse`, increment `press_count`.
    - Clear both pending flags.
- Bytes `00` and `FF` (keyboard error/overrun codes) are discarded and clear both pending flags. They generate no event.
- `press_count` wraps modulo 2^COUNT_W, so `FF`+1 gives `00`.
- `ovf_sticky` is set on any cycle with `overflow`=1 and is cleared only by reset.
- A make of a different key while `key_down`=1 replaces the held key (last-key-wins). A later break of the old key does not clear `key_down`.

## Timing
- Reset values (while `clrn`=0 at a `clk` edge):
  - State IDLE, `nextdata_n`=1.
  - `key_code`=00, `key_ext`=0, `key_down`=0.
  - Both pulses 0, `press_count`=0, `ovf_sticky`=0, pending flags 0.
- All outputs are registered; there is no combinational path from input to output.
- Throughput is one byte per 3 cycles. `nextdata_n` is low for exactly one cycle per byte.
- `press_pulse` and `release_pulse` assert in the cycle after PROC, i.e. 3 cycles after the IDLE cycle that sampled `ready`=1. `key_*` and `press_count` update in the same cycle as the pulse.
- `ready` is sampled only in IDLE. A `ready` that drops during POP/PROC has no effect.
- A prefix byte and its code byte may arrive back-to-back; pending flags persist across IDLE waits indefinitely.
- Reset asserted in POP or PROC aborts the byte in flight. The byte is lost or not popped depending on state; this is acceptable. `nextdata_n` returns to 1 at that edge.
- `overflow` and `ready` in the same cycle are independent: the flag is set and the pop proceeds normally.

## Structure
- Shared package `ps2_pkg`:
  - Constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_ERR0`=8'h00, `PS2_ERR1`=8'hFF.
  - State typedef `ps2_seq_state_t` {IDLE, POP, PROC}.
- Single module with no sub-module. The FSM, decoder and counter are one register-transfer block.
- The top level instantiates it between `ps2_keyboard` and `segment`, with `key_code[3:0]`/`[7:4]` driving the HEX0/HEX1 segment drivers.

## Test plan
- Reset then FIFO bytes `1C`:
  - `nextdata_n` low for 1 cycle.
  - `press_pulse` 3 cycles after `ready` is sampled.
  - `key_code`=1C, `key_down`=1, `press_count`=1.
- Bytes `1C 1C 1C F0 1C`:
  - `press_count`=1, one `press_pulse`, one `release_pulse`.
  - `key_down`=0 at end.
- Bytes `E0 75 E0 F0 75`:
  - `key_code`=75, `key_ext`=1 after the make; `key_down`=0 after the break.
  - A plain `F0 75` instead of `E0 F0 75` leaves `key_down`=1.
- Bytes `1C 32 F0 1C`:
  - `key_code`=32, `press_count`=2, `release_pulse` fires, `key_down` stays 1.
- 256 distinct make/break pairs: `press_count` wraps to 00 with a pulse on the 256th press.
- Mixed cases:
  - `overflow` pulse: `ovf_sticky`=1 until `clrn`=0.
  - Byte `FF` between `F0` and `1C`: discarded and `brk_pend` cleared, so `1C` is treated as a make.
  - Reset asserted in POP: `nextdata_n`=1 and all outputs at their reset values next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code consumer: prefix/error byte
// constants and the pop/decode sequencer state type.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PROC = 2'd2
    } ps2_seq_state_t;

    // Keyboard error/overrun codes carry no key information.
    function automatic logic ps2_is_err(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_sequencer.sv
// Pops scan-code bytes from the PS/2 receiver FIFO and turns E0/F0-prefixed
// byte streams into make/release events, held-key state and a press counter.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_down,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic               ovf_sticky
);

    ps2_seq_state_t     state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic [7:0]         key_code_q, key_code_d;
    logic               key_ext_q, key_ext_d;
    logic               key_down_q, key_down_d;
    logic               press_pulse_q, press_pulse_d;
    logic               release_pulse_q, release_pulse_d;
    logic [COUNT_W-1:0] press_count_q, press_count_d;
    logic               ovf_sticky_q, ovf_sticky_d;
    logic               ext_pend_q, ext_pend_d;
    logic               brk_pend_q, brk_pend_d;
    logic               same_key_s;

    assign same_key_s = (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

    // Next-state, pop handshake and scan-code decode.
    always_comb begin
        state_d         = state_q;
        byte_d          = byte_q;
        nextdata_n_d    = 1'b1;
        key_code_d      = key_code_q;
        key_ext_d       = key_ext_q;
        key_down_d      = key_down_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        press_count_d   = press_count_q;
        ovf_sticky_d    = ovf_sticky_q | overflow;
        ext_pend_d      = ext_pend_q;
        brk_pend_d      = brk_pend_q;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                    state_d      = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            POP: begin
                state_d = PROC;
            end
            PROC: begin
                state_d = IDLE;
                if (byte_q == PS2_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == PS2_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    // Error codes and key codes both terminate a prefix sequence.
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (ps2_is_err(byte_q)) begin
                        key_down_d = key_down_q;
                    end else if (brk_pend_q) begin
                        release_pulse_d = 1'b1;
                        if (same_key_s) begin
                            key_down_d = 1'b0;
                        end else begin
                            key_down_d = key_down_q;
                        end
                    end else if (!(key_down_q && same_key_s)) begin
                        key_code_d    = byte_q;
                        key_ext_d     = ext_pend_q;
                        key_down_d    = 1'b1;
                        press_pulse_d = 1'b1;
                        press_count_d = press_count_q + COUNT_W'(1);
                    end else begin
                        press_pulse_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q         <= IDLE;
            byte_q          <= 8'h00;
            nextdata_n_q    <= 1'b1;
            key_code_q      <= 8'h00;
            key_ext_q       <= 1'b0;
            key_down_q      <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= {COUNT_W{1'b0}};
            ovf_sticky_q    <= 1'b0;
            ext_pend_q      <= 1'b0;
            brk_pend_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_q          <= byte_d;
            nextdata_n_q    <= nextdata_n_d;
            key_code_q      <= key_code_d;
            key_ext_q       <= key_ext_d;
            key_down_q      <= key_down_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_count_q   <= press_count_d;
            ovf_sticky_q    <= ovf_sticky_d;
            ext_pend_q      <= ext_pend_d;
            brk_pend_q      <= brk_pend_d;
        end
    end

    assign nextdata_n    = nextdata_n_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_down      = key_down_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = press_count_q;
    assign ovf_sticky    = ovf_sticky_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: a queue-based receiver FIFO feeds bytes, and a
// per-byte event model predicts every output on every cycle.
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       nextdata_n, key_ext, key_down, press_pulse, release_pulse, ovf_sticky;
    logic [7:0] key_code;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    ps2_key_sequencer #(.COUNT_W(8)) dut (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
        .key_down(key_down), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .press_count(press_count), .ovf_sticky(ovf_sticky)
    );

    int total = 0;
    int bad = 0;

    // Receiver FIFO and stimulus state
    logic [7:0] fifo[$];
    bit         hold = 1'b0;
    logic       nd_seen = 1'b1;
    bit         chk_en = 1'b0;
    int         dut_press_n = 0;
    int         dut_rel_n = 0;

    // Behavioural model: per-byte decode, timing as "visible 3 edges after sampling"
    logic       m_nd = 1'b1, m_press = 1'b0, m_rel = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_ext = 1'b0, m_down = 1'b0, m_ovf = 1'b0;
    logic       m_ext_pend = 1'b0, m_brk_pend = 1'b0;
    int         m_presses = 0;
    bit         m_busy = 1'b0;
    int         ecount = 0;
    int         sched = 0;
    logic [7:0] m_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function void decode(input logic [7:0] x);
        if (x == 8'hE0) m_ext_pend = 1'b1;
        else if (x == 8'hF0) m_brk_pend = 1'b1;
        else begin
            if (x != 8'h00 && x != 8'hFF) begin
                if (m_brk_pend) begin
                    m_rel = 1'b1;
                    if (x == m_code && m_ext_pend == m_ext) m_down = 1'b0;
                end else if (!(m_down && x == m_code && m_ext_pend == m_ext)) begin
                    m_code = x;
                    m_ext = m_ext_pend;
                    m_down = 1'b1;
                    m_press = 1'b1;
                    m_presses++;
                end
            end
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end
    endfunction

    function void model_edge();
        ecount++;
        m_press = 1'b0;
        m_rel = 1'b0;
        m_nd = 1'b1;
        if (!clrn) begin
            m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_ovf = 1'b0;
            m_ext_pend = 1'b0; m_brk_pend = 1'b0; m_presses = 0; m_busy = 1'b0;
        end else begin
            if (overflow) m_ovf = 1'b1;
            if (m_busy && ecount == sched) begin
                decode(m_byte);
                m_busy = 1'b0;
            end else if (!m_busy && ready) begin
                m_byte = data;
                m_nd = 1'b0;
                m_busy = 1'b1;
                sched = ecount + 2;
            end
        end
    endfunction

    task automatic upd_in();
        ready = (fifo.size() > 0) && !hold;
        data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        upd_in();
    endtask

    // One clock: capture the pop strobe, advance the model, then service the FIFO.
    task automatic step();
        @(negedge clk);
        nd_seen = nextdata_n;
        @(posedge clk);
        model_edge();
        #1;
        if (nd_seen === 1'b0 && fifo.size() > 0) void'(fifo.pop_front());
        upd_in();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (fifo.size() == 0 && !m_busy) break;
            step();
        end
        check("drain_done", 32'(fifo.size() == 0 && !m_busy), 32'd1);
        step();
        step();
    endtask

    task automatic do_reset();
        fifo.delete();
        hold = 1'b0;
        overflow = 1'b0;
        upd_in();
        clrn = 1'b0;
        step();
        step();
        clrn = 1'b1;
        dut_press_n = 0;
        dut_rel_n = 0;
    endtask

    task automatic push_seq(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input int n);
        logic [7:0] s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < n; i++) push(s[i]);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("nextdata_n", 32'(nextdata_n), 32'(m_nd));
            check("key_code", 32'(key_code), 32'(m_code));
            check("key_ext", 32'(key_ext), 32'(m_ext));
            check("key_down", 32'(key_down), 32'(m_down));
            check("press_pulse", 32'(press_pulse), 32'(m_press));
            check("release_pulse", 32'(release_pulse), 32'(m_rel));
            check("press_count", 32'(press_count), 32'(m_presses % 256));
            check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
            if (press_pulse === 1'b1) dut_press_n++;
            if (release_pulse === 1'b1) dut_rel_n++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl [8];
        logic [7:0] code;
        tbl[0] = 8'hE0; tbl[1] = 8'hF0; tbl[2] = 8'h00; tbl[3] = 8'hFF;
        tbl[4] = 8'h1C; tbl[5] = 8'h1D; tbl[6] = 8'h75; tbl[7] = 8'h32;

        step();
        chk_en = 1'b1;
        do_reset();
        check("rst_nextdata_n", 32'(nextdata_n), 32'd1);
        check("rst_key_code", 32'(key_code), 32'h00);
        check("rst_press_count", 32'(press_count), 32'd0);

        // Single make: pop strobe width and pulse latency
        push(8'h1C);
        step();
        check("pop_low", 32'(nextdata_n), 32'd0);
        step();
        check("pop_one_cycle", 32'(nextdata_n), 32'd1);
        check("no_early_pulse", 32'(press_pulse), 32'd0);
        step();
        check("press_latency", 32'(press_pulse), 32'd1);
        drain();
        check("s1_code", 32'(key_code), 32'h1C);
        check("s1_down", 32'(key_down), 32'd1);
        check("s1_count", 32'(press_count), 32'd1);

        // Typematic repeats then break
        do_reset();
        push_seq(8'h1C, 8'h1C, 8'h1C, 8'hF0, 4);
        push(8'h1C);
        drain();
        check("s2_count", 32'(press_count), 32'd1);
        check("s2_press_n", 32'(dut_press_n), 32'd1);
        check("s2_rel_n", 32'(dut_rel_n), 32'd1);
        check("s2_down", 32'(key_down), 32'd0);

        // Extended make and extended break
        do_reset();
        push_seq(8'hE0, 8'h75, 8'h00, 8'h00, 2);
        drain();
        check("s3_code", 32'(key_code), 32'h75);
        check("s3_ext", 32'(key_ext), 32'd1);
        check("s3_down", 32'(key_down), 32'd1);
        push_seq(8'hE0, 8'hF0, 8'h75, 8'h00, 3);
        drain();
        check("s3_brk_down", 32'(key_down), 32'd0);

        // Plain break does not release an extended key
        do_reset();
        push_seq(8'hE0, 8'h75, 8'hF0, 8'h75, 4);
        drain();
        check("s3b_down", 32'(key_down), 32'd1);

        // Last key wins
        do_reset();
        push_seq(8'h1C, 8'h32, 8'hF0, 8'h1C, 4);
        drain();
        check("s4_code", 32'(key_code), 32'h32);
        check("s4_count", 32'(press_count), 32'd2);
        check("s4_rel_n", 32'(dut_rel_n), 32'd1);
        check("s4_down", 32'(key_down), 32'd1);

        // Error byte between break prefix and code
        do_reset();
        push_seq(8'hF0, 8'hFF, 8'h1C, 8'h00, 3);
        drain();
        check("s7_count", 32'(press_count), 32'd1);
        check("s7_down", 32'(key_down), 32'd1);
        check("s7_rel_n", 32'(dut_rel_n), 32'd0);

        // Overflow stickiness
        do_reset();
        overflow = 1'b1;
        step();
        overflow = 1'b0;
        step(); step(); step();
        check("ovf_set", 32'(ovf_sticky), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(ovf_sticky), 32'd0);

        // Reset while the pop strobe is low
        push(8'h1C);
        drain();
        push(8'h32);
        step();
        check("s8_in_pop", 32'(nextdata_n), 32'd0);
        clrn = 1'b0;
        step();
        check("s8_nd", 32'(nextdata_n), 32'd1);
        check("s8_code", 32'(key_code), 32'h00);
        check("s8_down", 32'(key_down), 32'd0);
        check("s8_count", 32'(press_count), 32'd0);
        clrn = 1'b1;
        step();

        // Counter wrap over 256 make/break pairs
        do_reset();
        for (int i = 0; i < 256; i++) begin
            code = 8'h10 + 8'(i % 96);
            push_seq(code, 8'hF0, code, 8'h00, 3);
            drain();
            if (i == 254) check("wrap_ff", 32'(press_count), 32'hFF);
        end
        check("wrap_00", 32'(press_count), 32'h00);
        check("wrap_pulses", 32'(dut_press_n), 32'd256);

        // Randomised byte stream with ready gaps and overflow blips
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 9) < 4) fifo.push_back(tbl[$urandom_range(0, 7)]);
            hold = ($urandom_range(0, 4) == 0);
            overflow = ($urandom_range(0, 99) == 0);
            upd_in();
        end
        hold = 1'b0;
        overflow = 1'b0;
        upd_in();
        drain();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
